// File: rtl/xcorr_seq_ctrl.sv
// Frame sequencer for the two-microphone cross-correlator: captures one frame of
// sample pairs into RAM, streams it back to the xcorr engine and waits for its results.
module xcorr_seq_ctrl #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int NRES  = 1023,
  parameter int TMO   = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          xc_en,
  input  logic          smp_valid,
  output logic          ram_wea,
  output logic [AW-1:0] ram_addra,
  output logic          ram_ceb,
  output logic [AW-1:0] ram_addrb,
  output logic          xc_start,
  input  logic          xc_complete,
  output logic          busy,
  output logic          done,
  output logic          ovr,
  output logic          tmo_err
);

  localparam int RW = $clog2(NRES + 1);
  localparam int TW = $clog2(TMO + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CAPTURE  = 3'd1;
  localparam logic [2:0] READ     = 3'd2;
  localparam logic [2:0] WAIT_RES = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [RW-1:0] RES_FULL  = RW'(NRES);
  localparam logic [RW-1:0] RES_LAST  = RW'(NRES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO - 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_cnt;
  logic [RW-1:0] res_cnt;
  logic [TW-1:0] tmo_cnt;

  logic in_idle;
  logic in_cap;
  logic in_read;
  logic in_wait;
  logic in_done;
  logic frame_start;
  logic wr_last;
  logic rd_last;
  logic res_hit;
  logic tmo_hit;
  logic res_inc;

  assign in_idle = (state == IDLE);
  assign in_cap  = (state == CAPTURE);
  assign in_read = (state == READ);
  assign in_wait = (state == WAIT_RES);
  assign in_done = (state == DONE);

  assign frame_start = in_idle & xc_en;
  assign wr_last     = (wr_cnt == LAST_ADDR);
  assign rd_last     = (rd_cnt == LAST_ADDR);

  // The completing strobe counts in its own cycle, so the frame can end one cycle after it.
  assign res_hit = (res_cnt == RES_FULL) | (xc_complete & (res_cnt == RES_LAST));
  assign tmo_hit = (tmo_cnt == TMO_LAST);
  assign res_inc = xc_complete & (in_read | in_wait) & (res_cnt != RES_FULL);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (xc_en) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        // An enable drop wins over a simultaneous final write: the frame is discarded.
        if (!xc_en)                    state_nxt = IDLE;
        else if (smp_valid && wr_last) state_nxt = READ;
      end
      READ: begin
        if (rd_last) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_hit || tmo_hit) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (in_idle) begin
      wr_cnt <= '0;
    end else if (in_cap && smp_valid && !wr_last) begin
      wr_cnt <= wr_cnt + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
    end else if (in_idle) begin
      rd_cnt <= '0;
    end else if (in_read && !rd_last) begin
      rd_cnt <= rd_cnt + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt <= '0;
    end else if (in_idle) begin
      res_cnt <= '0;
    end else if (res_inc) begin
      res_cnt <= res_cnt + RW'(1);
    end
  end

  // Counts cycles spent in WAIT_RES; restarts from zero on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (!in_wait) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr <= 1'b0;
    end else if (frame_start) begin
      ovr <= 1'b0;
    end else if (smp_valid && (in_read || in_wait || in_done)) begin
      ovr <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_err <= 1'b0;
    end else if (frame_start) begin
      tmo_err <= 1'b0;
    end else if (in_wait && tmo_hit && !res_hit) begin
      tmo_err <= 1'b1;
    end
  end

  assign ram_wea   = in_cap & smp_valid;
  assign ram_addra = in_cap ? wr_cnt : '0;
  assign ram_ceb   = in_read;
  assign ram_addrb = in_read ? rd_cnt : '0;
  assign xc_start  = in_read & (rd_cnt == '0);
  assign busy      = ~in_idle;
  assign done      = in_done;

endmodule

// File: tb/tb_xcorr_seq_ctrl.sv
// Directed bench for xcorr_seq_ctrl: a frame-level model checked every cycle on the
// falling edge, plus hand-computed literal checks at the interesting moments.
module tb_xcorr_seq_ctrl;

  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int NRES  = 1023;
  localparam int TMO   = 4096;

  localparam int M_IDLE = 0;
  localparam int M_CAP  = 1;
  localparam int M_READ = 2;
  localparam int M_WAIT = 3;
  localparam int M_DONE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          xc_en;
  logic          smp_valid;
  logic          xc_complete;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic          ram_ceb;
  logic [AW-1:0] ram_addrb;
  logic          xc_start;
  logic          busy;
  logic          done;
  logic          ovr;
  logic          tmo_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wea    = 0;
  int n_ceb    = 0;
  int n_done   = 0;
  int n_start  = 0;

  // Frame-level model: which phase we are in plus plain sample/read/result tallies.
  int m_mode = M_IDLE;
  int m_wr   = 0;
  int m_rd   = 0;
  int m_res  = 0;
  int m_wait = 0;
  int m_ovr  = 0;
  int m_tmo  = 0;

  int e_wea, e_addra, e_ceb, e_addrb, e_start, e_busy, e_done;

  xcorr_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .NRES(NRES), .TMO(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .xc_en      (xc_en),
    .smp_valid  (smp_valid),
    .ram_wea    (ram_wea),
    .ram_addra  (ram_addra),
    .ram_ceb    (ram_ceb),
    .ram_addrb  (ram_addrb),
    .xc_start   (xc_start),
    .xc_complete(xc_complete),
    .busy       (busy),
    .done       (done),
    .ovr        (ovr),
    .tmo_err    (tmo_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_mode = M_IDLE;
      m_wr   = 0;
      m_rd   = 0;
      m_res  = 0;
      m_wait = 0;
      m_ovr  = 0;
      m_tmo  = 0;
    end
    e_wea   = (m_mode == M_CAP && smp_valid === 1'b1) ? 1 : 0;
    e_addra = (m_mode == M_CAP) ? m_wr : 0;
    e_ceb   = (m_mode == M_READ) ? 1 : 0;
    e_addrb = (m_mode == M_READ) ? m_rd : 0;
    e_start = (m_mode == M_READ && m_rd == 0) ? 1 : 0;
    e_busy  = (m_mode != M_IDLE) ? 1 : 0;
    e_done  = (m_mode == M_DONE) ? 1 : 0;
    checkOutput("cmp_wea",      32'(ram_wea),   e_wea);
    checkOutput("cmp_addra",    32'(ram_addra), e_addra);
    checkOutput("cmp_ceb",      32'(ram_ceb),   e_ceb);
    checkOutput("cmp_addrb",    32'(ram_addrb), e_addrb);
    checkOutput("cmp_xc_start", 32'(xc_start),  e_start);
    checkOutput("cmp_busy",     32'(busy),      e_busy);
    checkOutput("cmp_done",     32'(done),      e_done);
    checkOutput("cmp_ovr",      32'(ovr),       m_ovr);
    checkOutput("cmp_tmo_err",  32'(tmo_err),   m_tmo);
    if (ram_wea === 1'b1)  n_wea++;
    if (ram_ceb === 1'b1)  n_ceb++;
    if (done === 1'b1)     n_done++;
    if (xc_start === 1'b1) n_start++;
    if (!rst) begin
      case (m_mode)
        M_IDLE: begin
          if (xc_en) begin
            m_mode = M_CAP;
            m_wr   = 0;
            m_rd   = 0;
            m_res  = 0;
            m_ovr  = 0;
            m_tmo  = 0;
          end
        end
        M_CAP: begin
          if (!xc_en) begin
            m_mode = M_IDLE;
          end else if (smp_valid) begin
            m_wr++;
            if (m_wr == DEPTH) m_mode = M_READ;
          end
        end
        M_READ: begin
          if (smp_valid) m_ovr = 1;
          if (xc_complete) m_res++;
          m_rd++;
          if (m_rd == DEPTH) begin
            m_mode = M_WAIT;
            m_wait = 0;
          end
        end
        M_WAIT: begin
          if (smp_valid) m_ovr = 1;
          if (xc_complete) m_res++;
          m_wait++;
          if (m_res >= NRES) begin
            m_mode = M_DONE;
          end else if (m_wait == TMO) begin
            m_tmo  = 1;
            m_mode = M_DONE;
          end
        end
        default: begin
          if (smp_valid) m_ovr = 1;
          m_mode = M_IDLE;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of strobes (xc_en is left as it is) and clears them afterwards.
  task automatic applyStimulus(input logic sv, input logic cmp);
    smp_valid   = sv;
    xc_complete = cmp;
    tick();
    smp_valid   = 1'b0;
    xc_complete = 1'b0;
  endtask

  task automatic sendSamples(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (i != n - 1) repeat (gap - 1) tick();
    end
  endtask

  task automatic sendCompletes(input int n);
    repeat (n) applyStimulus(1'b0, 1'b1);
  endtask

  task automatic waitCeb(input logic value, input int budget, input string name);
    int k = 0;
    while (ram_ceb !== value && k < budget) begin
      tick();
      k++;
    end
    checkOutput(name, 32'(ram_ceb), 32'(value));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    xc_en = 1'b0;
    smp_valid = 1'b0;
    xc_complete = 1'b0;
    repeat (3) tick();
    checkOutput("reset_busy",  32'(busy),      0);
    checkOutput("reset_addra", 32'(ram_addra), 0);
    checkOutput("reset_addrb", 32'(ram_addrb), 0);
    checkOutput("reset_ovr",   32'(ovr),       0);
    rst = 1'b0;
    tick();

    // Samples while idle are ignored.
    applyStimulus(1'b1, 1'b0);
    checkOutput("idle_smp_ovr",  32'(ovr),  0);
    checkOutput("idle_smp_busy", 32'(busy), 0);

    // Frame A: slow capture, enable dropped during READ, full result set.
    xc_en = 1'b1;
    tick();
    checkOutput("A_capture_busy", 32'(busy), 1);
    applyStimulus(1'b0, 1'b1);
    sendSamples(DEPTH, 10);
    checkOutput("A_first_start", 32'(xc_start),  1);
    checkOutput("A_first_addrb", 32'(ram_addrb), 0);
    checkOutput("A_first_ceb",   32'(ram_ceb),   1);
    xc_en = 1'b0;
    waitCeb(1'b0, DEPTH + 8, "A_read_end");
    sendCompletes(NRES);
    checkOutput("A_done_pulse", 32'(done),    1);
    checkOutput("A_tmo_err",    32'(tmo_err), 0);
    tick();
    checkOutput("A_idle_busy", 32'(busy), 0);
    checkOutput("A_idle_done", 32'(done), 0);
    checkOutput("A_writes",    32'(n_wea),   512);
    checkOutput("A_reads",     32'(n_ceb),   512);
    checkOutput("A_starts",    32'(n_start), 1);
    checkOutput("A_dones",     32'(n_done),  1);

    // Frame B: abort after 100 writes.
    xc_en = 1'b1;
    tick();
    sendSamples(100, 3);
    xc_en = 1'b0;
    tick();
    checkOutput("B_abort_busy", 32'(busy), 0);
    repeat (5) tick();
    checkOutput("B_writes", 32'(n_wea),  612);
    checkOutput("B_reads",  32'(n_ceb),  512);
    checkOutput("B_dones",  32'(n_done), 1);

    // Frame C: overrun during READ, then result timeout.
    xc_en = 1'b1;
    tick();
    sendSamples(DEPTH, 1);
    checkOutput("C_first_start", 32'(xc_start), 1);
    repeat (5) tick();
    smp_valid = 1'b1;
    #1;
    checkOutput("C_ovr_no_write", 32'(ram_wea), 0);
    checkOutput("C_ovr_ceb",      32'(ram_ceb), 1);
    @(posedge clk);
    #1;
    smp_valid = 1'b0;
    checkOutput("C_ovr_set", 32'(ovr), 1);
    waitCeb(1'b0, DEPTH + 8, "C_read_end");
    sendCompletes(10);
    repeat (TMO - 11) tick();
    checkOutput("C_pre_tmo_done", 32'(done),    0);
    checkOutput("C_pre_tmo_busy", 32'(busy),    1);
    checkOutput("C_pre_tmo_err",  32'(tmo_err), 0);
    tick();
    checkOutput("C_tmo_done", 32'(done),    1);
    checkOutput("C_tmo_err",  32'(tmo_err), 1);
    tick();
    checkOutput("C_idle_busy",  32'(busy), 0);
    checkOutput("C_idle_ovr",   32'(ovr),  1);
    tick();
    checkOutput("C_recap_busy", 32'(busy),    1);
    checkOutput("C_recap_ovr",  32'(ovr),     0);
    checkOutput("C_recap_tmo",  32'(tmo_err), 0);
    checkOutput("C_dones",      32'(n_done),  2);

    // Frame D: reset asserted mid-READ at address 200.
    sendSamples(DEPTH, 1);
    repeat (200) tick();
    checkOutput("D_addrb_200", 32'(ram_addrb), 200);
    rst = 1'b1;
    #1;
    checkOutput("D_rst_ceb",   32'(ram_ceb),   0);
    checkOutput("D_rst_addrb", 32'(ram_addrb), 0);
    checkOutput("D_rst_busy",  32'(busy),      0);
    checkOutput("D_rst_start", 32'(xc_start),  0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("D_post_rst_busy", 32'(busy), 0);
    tick();
    checkOutput("D_recap_busy", 32'(busy), 1);

    // Frame E: clean frame, some results already arriving during READ.
    sendSamples(DEPTH, 2);
    sendCompletes(5);
    waitCeb(1'b0, DEPTH + 8, "E_read_end");
    sendCompletes(NRES - 5);
    checkOutput("E_done_pulse", 32'(done),    1);
    checkOutput("E_tmo_err",    32'(tmo_err), 0);
    tick();
    checkOutput("E_idle_busy", 32'(busy), 0);
    tick();
    checkOutput("E_dones", 32'(n_done), 3);

    // Frame F: enable drops in the same cycle as the final write.
    sendSamples(DEPTH - 1, 1);
    xc_en = 1'b0;
    smp_valid = 1'b1;
    #1;
    checkOutput("F_last_wea",   32'(ram_wea),   1);
    checkOutput("F_last_addra", 32'(ram_addra), DEPTH - 1);
    @(posedge clk);
    #1;
    smp_valid = 1'b0;
    checkOutput("F_abort_busy", 32'(busy),    0);
    checkOutput("F_abort_ceb",  32'(ram_ceb), 0);
    repeat (3) tick();
    checkOutput("F_starts", 32'(n_start), 4);
    checkOutput("F_dones",  32'(n_done),  3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
